agc_ctr_sched: RTL

//  Counter-cell increment scheduler for the AGC central datapath. Latches PINC/MINC/PCDU/MCDU

---
 rtl/agc_ctr_pkg.sv | 44 ++++
 rtl/agc_ctr_prio_enc.sv | 32 +++
 rtl/agc_ctr_sched.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/agc_ctr_pkg.sv
// -----------------------------------------------------------------------------
// agc_ctr_pkg
//   Shared types and constants for the AGC involuntary-counter scheduler.
//   - ctr_op_t  : increment operation presented to the sequencer
//   - state_t   : scheduler FSM state
//   - counter address constants for the fixed counter cells
//   - make_op() : builds the op code from the CDU flag and sign
// -----------------------------------------------------------------------------
package agc_ctr_pkg;

    // Encoding is {cdu, minus}, so the op can be assembled directly from
    // the counter's CDU flag and the sign of its pending request.
    typedef enum logic [1:0] {
        PINC = 2'd0,
        MINC = 2'd1,
        PCDU = 2'd2,
        MCDU = 2'd3
    } ctr_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Largest supported counter array; index width is derived from NCTR.
    localparam int unsigned CTR_MAX = 32;

    // Erasable addresses of the involuntary counters (index 0 at 12'o0024).
    localparam logic [11:0] CTR_ADDR_BASE = 12'o0024;
    localparam logic [11:0] CTR_TIME2     = 12'o0024;
    localparam logic [11:0] CTR_TIME1     = 12'o0025;
    localparam logic [11:0] CTR_TIME3     = 12'o0026;
    localparam logic [11:0] CTR_TIME4     = 12'o0027;
    localparam logic [11:0] CTR_TIME5     = 12'o0030;
    localparam logic [11:0] CTR_TIME6     = 12'o0031;
    localparam logic [11:0] CTR_CDUX      = 12'o0032;
    localparam logic [11:0] CTR_CDUY      = 12'o0033;
    localparam logic [11:0] CTR_CDUZ      = 12'o0034;

    function automatic ctr_op_t make_op(input logic cdu, input logic minus);
        return ctr_op_t'({cdu, minus});
    endfunction

endpackage

// File: rtl/agc_ctr_prio_enc.sv
// -----------------------------------------------------------------------------
// agc_ctr_prio_enc
//   Fixed-priority encoder: reports the lowest set bit of req.
//   Ports:
//     req    in   N       request vector, bit 0 = highest priority
//     valid  out  1       any bit of req set
//     idx    out  IDX_W   index of the lowest set bit (0 when none)
//   Purely combinational.
// -----------------------------------------------------------------------------
module agc_ctr_prio_enc #(
    parameter int unsigned N     = 20,
    parameter int unsigned IDX_W = 5
) (
    input  logic [N-1:0]     req,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path
        // leaves it unassigned and no latch is inferred.
        valid = |req;
        idx   = '0;
        // Scan from the top down so the last hit written is the lowest index.
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/agc_ctr_sched.sv
// -----------------------------------------------------------------------------
// agc_ctr_sched
//   Involuntary-counter increment scheduler. Latches plus/minus requests per
//   counter cell and, at a memory-cycle boundary, steals a counter cycle
//   (INKL) for the highest-priority pending counter, presenting its erasable
//   address and increment op to the sequencer.
//   Ports:
//     CLOCK      in   1     system clock
//     SIM_RST_n  in   1     asynchronous active-low reset
//     GOJAM      in   1     synchronous restart: drop all pending, abort grant
//     REQ_P      in   NCTR  plus-increment pulse per counter
//     REQ_M      in   NCTR  minus-increment pulse per counter
//     CYCLE_END  in   1     end-of-memory-cycle pulse (T12)
//     INHCTR     in   1     inhibits new grants while high
//     CTR_DONE   in   1     sequencer finished the current counter cycle
//     INKL       out  1     counter cycle granted / in service
//     CTR_ADDR   out  12    erasable address of the granted counter
//     CTR_OP     out  2     PINC / MINC / PCDU / MCDU
//     PEND_ANY   out  1     any counter pending or in service
//     LOST       out  1     pulse: a duplicate request was dropped
// -----------------------------------------------------------------------------
module agc_ctr_sched
    import agc_ctr_pkg::*;
#(
    parameter int unsigned     NCTR      = 20,
    parameter logic [11:0]     ADDR_BASE = 12'o0024,
    parameter logic [NCTR-1:0] CDU_MASK  = '0
) (
    input  logic            CLOCK,
    input  logic            SIM_RST_n,
    input  logic            GOJAM,
    input  logic [NCTR-1:0] REQ_P,
    input  logic [NCTR-1:0] REQ_M,
    input  logic            CYCLE_END,
    input  logic            INHCTR,
    input  logic            CTR_DONE,
    output logic            INKL,
    output logic [11:0]     CTR_ADDR,
    output logic [1:0]      CTR_OP,
    output logic            PEND_ANY,
    output logic            LOST
);

    localparam int unsigned IDX_W = (NCTR > 1) ? $clog2(NCTR) : 1;

    // Pending latches. When a counter is granted its latch is moved into
    // service (cleared here) and the service itself is represented by
    // state == ST_BUSY. Any request that reaches the in-service counter
    // therefore lands in an empty latch and becomes a fresh pending entry,
    // which is also why a request in the CTR_DONE cycle survives the clear.
    logic [NCTR-1:0] pp;
    logic [NCTR-1:0] pm;
    logic [NCTR-1:0] pp_nxt;
    logic [NCTR-1:0] pm_nxt;
    logic [NCTR-1:0] lost_vec;
    logic [NCTR-1:0] win_mask;

    state_t          state;
    logic            rearb;      // BUSY cycle spent picking the chained winner
    logic            win_valid;
    logic [IDX_W-1:0] win_idx;
    logic            take;       // a counter is granted at this edge

    agc_ctr_prio_enc #(
        .N     (NCTR),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .req   (pp | pm),
        .valid (win_valid),
        .idx   (win_idx)
    );

    // A grant happens either from IDLE at a qualifying cycle boundary, or in
    // the re-arbitration cycle that follows a chained CTR_DONE. The chaining
    // decision was already qualified by INHCTR in the CTR_DONE cycle.
    assign take = !GOJAM && win_valid &&
                  (((state == ST_IDLE) && CYCLE_END && !INHCTR) ||
                   ((state == ST_BUSY) && rearb));

    always_comb begin
        win_mask = '0;
        if (take) begin
            win_mask[win_idx] = 1'b1;
        end
    end

    // Next pending state: remove a counter entering service, then apply this
    // cycle's requests. Opposite signs cancel; a repeat of the same sign on
    // an already-pending counter is dropped and flagged.
    always_comb begin
        pp_nxt   = pp & ~win_mask;
        pm_nxt   = pm & ~win_mask;
        lost_vec = '0;
        for (int i = 0; i < int'(NCTR); i++) begin
            if (REQ_P[i] && !REQ_M[i]) begin
                if (pm_nxt[i]) begin
                    pm_nxt[i] = 1'b0;
                end else if (pp_nxt[i]) begin
                    lost_vec[i] = 1'b1;
                end else begin
                    pp_nxt[i] = 1'b1;
                end
            end else if (REQ_M[i] && !REQ_P[i]) begin
                if (pp_nxt[i]) begin
                    pp_nxt[i] = 1'b0;
                end else if (pm_nxt[i]) begin
                    lost_vec[i] = 1'b1;
                end else begin
                    pm_nxt[i] = 1'b1;
                end
            end
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLOCK or negedge SIM_RST_n) begin
        if (!SIM_RST_n) begin
            // NOTE: the pending array is a flop bank, not RAM, and must come
            // out of reset empty, so it is reset like any other state.
            pp       <= '0;
            pm       <= '0;
            state    <= ST_IDLE;
            rearb    <= 1'b0;
            INKL     <= 1'b0;
            CTR_ADDR <= '0;
            CTR_OP   <= PINC;
            LOST     <= 1'b0;
        end else if (GOJAM) begin
            // Restart discards everything, including same-cycle requests.
            pp    <= '0;
            pm    <= '0;
            state <= ST_IDLE;
            rearb <= 1'b0;
            INKL  <= 1'b0;
            LOST  <= 1'b0;
        end else begin
            pp   <= pp_nxt;
            pm   <= pm_nxt;
            LOST <= |lost_vec;
            if (take) begin
                state    <= ST_BUSY;
                rearb    <= 1'b0;
                INKL     <= 1'b1;
                CTR_ADDR <= ADDR_BASE + 12'(win_idx);
                CTR_OP   <= make_op(CDU_MASK[win_idx], pm[win_idx]);
            end else begin
                case (state)
                    ST_IDLE: begin
                        // CTR_DONE is meaningless without a grant.
                    end
                    ST_BUSY: begin
                        if (rearb) begin
                            // Nothing left to chain to (all cancelled).
                            state <= ST_IDLE;
                            rearb <= 1'b0;
                            INKL  <= 1'b0;
                        end else if (CTR_DONE) begin
                            // CYCLE_END is ignored while busy; only CTR_DONE
                            // ends a service.
                            if ((|(pp_nxt | pm_nxt)) && !INHCTR) begin
                                rearb <= 1'b1;
                            end else begin
                                state <= ST_IDLE;
                                INKL  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        INKL  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // The in-service counter still counts as pending until CTR_DONE.
    assign PEND_ANY = (|pp) | (|pm) | (state == ST_BUSY);

endmodule
